// File: rtl/prefetch_fifo_frame_reader_if.sv
// ---------------------------------------------------------------------------
// prefetch_fifo_frame_reader_if
//
// Bundles the signals of the prefetch FIFO frame reader: the frame control
// inputs, the FIFO show-ahead read port, the downstream valid/ready byte
// stream and the status outputs.
//
// Modports:
//   master - the frame reader itself (drives fifo_rd_en, out_*, busy, done,
//            len_err; receives start, frame_len, fifo_rd_*, out_ready)
//   slave  - the surrounding logic (FIFO, controller and downstream sink)
//
// Parameters:
//   DATA_W - byte width, matches the FIFO read data width
//   LEN_W  - frame length width
// ---------------------------------------------------------------------------
interface prefetch_fifo_frame_reader_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) ();
    // Frame control
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    // FIFO show-ahead read port
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_vld;
    logic              fifo_rd_en;
    // Output byte stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    // Status
    logic              busy;
    logic              done;
    logic              len_err;

    modport master (
        input  start, frame_len, fifo_rd_data, fifo_rd_vld, out_ready,
        output fifo_rd_en, out_data, out_valid, out_sof, out_eof,
               busy, done, len_err
    );

    modport slave (
        output start, frame_len, fifo_rd_data, fifo_rd_vld, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_sof, out_eof,
               busy, done, len_err
    );
endinterface

// File: rtl/prefetch_fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// prefetch_fifo_frame_reader
//
// Drains bytes from the prefetch FIFO's show-ahead read port in frames of a
// programmed length and emits each frame as a registered valid/ready byte
// stream with start-of-frame / end-of-frame markers. Runs in the FIFO's read
// clock domain.
//
// Ports:
//   clk    - FIFO read clock
//   rst_n  - asynchronous active-low reset
//   bus    - prefetch_fifo_frame_reader_if.master:
//            start/frame_len   frame request (sampled only when idle)
//            fifo_rd_data/vld  FIFO show-ahead data in
//            fifo_rd_en        FIFO pop (combinational, gated by fifo_rd_vld)
//            out_data/valid/ready/sof/eof  registered output byte stream
//            busy              high whenever not idle
//            done              one-cycle pulse after the eof byte is accepted
//            len_err           one-cycle pulse on a start with frame_len==0
//
// Build option:
//   FRAME_READER_CRC_EN - when defined, a CRC-8 byte (poly 0x07, init 0x00,
//   MSB-first, no reflection, no final XOR) over the payload is appended to
//   every frame and carries out_eof. When undefined, out_eof marks the last
//   payload byte and no CRC logic exists.
// ---------------------------------------------------------------------------
module prefetch_fifo_frame_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic clk,
    input  logic rst_n,
    prefetch_fifo_frame_reader_if.master bus
);

`ifdef FRAME_READER_CRC_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAIL   = 2'd2,
        FLUSH   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FLUSH   = 2'd3
    } state_t;
`endif

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  remain_reg;
    logic              first_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              out_sof_reg;
    logic              out_eof_reg;
    logic              done_reg;
    logic              len_err_reg;

    logic reg_free;   // output register can take a new byte this cycle
    logic accept;     // current output byte is consumed downstream
    logic pop;        // a FIFO byte is taken this cycle
    logic last_pop;   // the pop that carries the final payload byte
    logic start_ok;
    logic start_bad;

    always_comb begin
        reg_free  = ~out_valid_reg | bus.out_ready;
        accept    = out_valid_reg & bus.out_ready;
        pop       = (state_reg == PAYLOAD) & bus.fifo_rd_vld & reg_free;
        last_pop  = pop & (remain_reg == LEN_W'(1));
        start_ok  = (state_reg == IDLE) & bus.start & (bus.frame_len != '0);
        start_bad = (state_reg == IDLE) & bus.start & (bus.frame_len == '0);
    end

`ifdef FRAME_READER_CRC_EN
    logic [7:0] crc_reg;
    logic       trail_load;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                               input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always_comb begin
        trail_load = (state_reg == TRAIL) & reg_free;
    end

    // Running CRC over the payload; cleared whenever a frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= 8'h00;
        end else if (start_ok) begin
            crc_reg <= 8'h00;
        end else if (pop) begin
            crc_reg <= crc8_update(crc_reg, 8'(bus.fifo_rd_data));
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = PAYLOAD;
            end
            PAYLOAD: begin
`ifdef FRAME_READER_CRC_EN
                if (last_pop) state_next = TRAIL;
`else
                if (last_pop) state_next = FLUSH;
`endif
            end
`ifdef FRAME_READER_CRC_EN
            TRAIL: begin
                if (reg_free) state_next = FLUSH;
            end
`endif
            FLUSH: begin
                // Only the eof byte can be in the output register here.
                if (accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Length counter and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_reg    <= '0;
            first_reg     <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            done_reg      <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            len_err_reg <= start_bad;

            if (start_ok) begin
                remain_reg <= bus.frame_len;
                first_reg  <= 1'b1;
            end

            if (pop) begin
                out_data_reg  <= bus.fifo_rd_data;
                out_valid_reg <= 1'b1;
                out_sof_reg   <= first_reg;
                first_reg     <= 1'b0;
`ifdef FRAME_READER_CRC_EN
                out_eof_reg   <= 1'b0;
`else
                out_eof_reg   <= last_pop;
`endif
                // remain parks at 1 after the final pop instead of wrapping.
                if (!last_pop) begin
                    remain_reg <= remain_reg - LEN_W'(1);
                end
            end
`ifdef FRAME_READER_CRC_EN
            else if (trail_load) begin
                out_data_reg  <= DATA_W'(crc_reg);
                out_valid_reg <= 1'b1;
                out_sof_reg   <= 1'b0;
                out_eof_reg   <= 1'b1;
            end
`endif
            else if (accept) begin
                out_valid_reg <= 1'b0;
                out_sof_reg   <= 1'b0;
                out_eof_reg   <= 1'b0;
            end

            if ((state_reg == FLUSH) && accept) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_data   = out_data_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_sof    = out_sof_reg;
    assign bus.out_eof    = out_eof_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_reg;
    assign bus.len_err    = len_err_reg;

endmodule

// File: tb/tb_prefetch_fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_prefetch_fifo_frame_reader
//
// Directed bench for prefetch_fifo_frame_reader. A queue models the FIFO
// show-ahead port; every byte loaded into it also pushes the expected output
// entry {data, sof, eof} to a scoreboard, which is popped whenever the DUT
// hands a byte downstream. Works for both builds (FRAME_READER_CRC_EN on/off).
// ---------------------------------------------------------------------------
module tb_prefetch_fifo_frame_reader;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 11;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prefetch_fifo_frame_reader_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    prefetch_fifo_frame_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pops = 0;
    int         sof_cnt = 0;
    int         eof_cnt = 0;
    int         done_cyc = -1;
    int         first_pop_cyc = -1;
    int         stall_at = -1;
    int         starve_left = 0;
    bit         vld_en = 1'b1;
    bit         bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;   // out_ready 1,0,0,1 by cyc%4
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic [7:0] fifo_q[$];
    logic [9:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] crc_in,
                                        input logic [7:0] d);
        logic [7:0] c;
        c = crc_in;
        for (int k = 7; k >= 0; k--) begin
            if (c[7] ^ d[k]) c = (c << 1) ^ 8'h07;
            else             c = c << 1;
        end
        return c;
    endfunction

    task automatic fifo_refresh();
        bus.fifo_rd_vld  = vld_en && (fifo_q.size() > 0);
        bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock: monitor at negedge, FIFO pop at posedge, drive at posedge+1.
    task automatic tick();
        logic       pop_now;
        logic       acc_now;
        logic [9:0] exp_e;
        int         s;
        @(negedge clk);
        s       = cyc;
        pop_now = rst_n && bus.fifo_rd_en && bus.fifo_rd_vld;
        acc_now = rst_n && bus.out_valid && bus.out_ready;
        if (rst_n) begin
            if (bus.fifo_rd_en) check("rd_en_without_vld", bus.fifo_rd_vld, 1);
            if (stall_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, stall_data);
            end
            if (bus.out_valid && !bus.out_ready)
                check("pop_while_stalled", bus.fifo_rd_en, 0);
            if (acc_now) begin
                if (sb.size() != 0) exp_e = sb.pop_front();
                else                exp_e = 10'bx;
                check("out_byte", {bus.out_data, bus.out_sof, bus.out_eof}, exp_e);
                $display("[TB] cyc %0d byte %02h sof %0b eof %0b", s,
                         bus.out_data, bus.out_sof, bus.out_eof);
                if (bus.out_sof) sof_cnt++;
                if (bus.out_eof) eof_cnt++;
                last_data = bus.out_data;
            end
            if (bus.done) done_cyc = s;
        end
        stall_prev = rst_n && bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        @(posedge clk);
        cyc++;
        if (pop_now) begin
            void'(fifo_q.pop_front());
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = s;
        end
        #1;
        bus.out_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
        if (stall_at >= 0 && pops == stall_at) begin
            vld_en      = 1'b0;
            starve_left = 5;
            stall_at    = -1;
        end else if (starve_left > 0) begin
            starve_left--;
            if (starve_left == 0) vld_en = 1'b1;
        end
        fifo_refresh();
    endtask

    task automatic load_frame(input int n, input logic [7:0] base);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            fifo_q.push_back(b);
            c = crc8(c, b);
`ifdef FRAME_READER_CRC_EN
            sb.push_back({b, (i == 0), 1'b0});
`else
            sb.push_back({b, (i == 0), (i == n - 1)});
`endif
        end
`ifdef FRAME_READER_CRC_EN
        sb.push_back({c, 1'b0, 1'b1});
`endif
        fifo_refresh();
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (done_cyc < 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, (done_cyc >= 0), 1);
    endtask

    task automatic run_frame(input string tag, input int n,
                             input logic [7:0] base, output int t0);
        int p0;
        p0            = pops;
        sof_cnt       = 0;
        eof_cnt       = 0;
        first_pop_cyc = -1;
        done_cyc      = -1;
        load_frame(n, base);
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(n);
        t0            = cyc;
        tick();
        bus.start     = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        wait_done(tag, n * 4 + 40);
        check({tag, "_pops"}, pops - p0, n);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_sof_cnt"}, sof_cnt, 1);
        check({tag, "_eof_cnt"}, eof_cnt, 1);
        check({tag, "_idle_after"}, bus.busy, 0);
    endtask

    initial begin
        int t0;
        int p0;
        int n;
        rst_n            = 1'b1;
        bus.start        = 1'b0;
        bus.frame_len    = '0;
        bus.out_ready    = 1'b1;
        bus.fifo_rd_vld  = 1'b0;
        bus.fifo_rd_data = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_outputs",
              {bus.fifo_rd_en, bus.out_data, bus.out_valid, bus.out_sof,
               bus.out_eof, bus.busy, bus.done, bus.len_err}, 0);
        rst_n = 1'b1;
        tick();
        check("rst_idle", bus.busy, 0);

        // Basic 4-byte frame
        run_frame("basic", 4, 8'hA0, t0);
        check("basic_first_pop", first_pop_cyc, t0 + 1);
`ifdef FRAME_READER_CRC_EN
        check("basic_done_time", done_cyc, t0 + 7);
`else
        check("basic_done_time", done_cyc, t0 + 6);
        check("basic_last_byte", last_data, 8'hA3);
`endif
        tick();

        // "123456789" payload; CRC build appends the check value 0xF4
        run_frame("crc9", 9, 8'h31, t0);
`ifdef FRAME_READER_CRC_EN
        check("crc9_crc_byte", last_data, 8'hF4);
        check("crc9_done_time", done_cyc, t0 + 12);
`else
        check("crc9_last_byte", last_data, 8'h39);
        check("crc9_done_time", done_cyc, t0 + 11);
`endif
        tick();

        // Backpressure: out_ready 1,0,0,1
        bp_mode = 1'b1;
        tick();
        run_frame("backpressure", 6, 8'h10, t0);
        bp_mode = 1'b0;
        tick();

        // FIFO starvation for 5 cycles after the third pop
        stall_at = pops + 3;
        run_frame("starve", 8, 8'h60, t0);
        check("starve_vld_restored", vld_en, 1);
        tick();

        // Zero length request
        p0            = pops;
        bus.start     = 1'b1;
        bus.frame_len = '0;
        tick();
        bus.start     = 1'b0;
        check("len0_err_pulse", bus.len_err, 1);
        check("len0_busy", bus.busy, 0);
        tick();
        check("len0_err_clear", bus.len_err, 0);
        check("len0_no_pop", pops - p0, 0);

        // Maximum length frame
        run_frame("len2047", 2047, 8'h00, t0);
        tick();

        // Start while busy is ignored; extra FIFO bytes must stay put
        p0 = pops;
        load_frame(3, 8'h50);
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hE0 + 8'(i));
        fifo_refresh();
        done_cyc      = -1;
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(3);
        tick();
        bus.start     = 1'b0;
        tick();
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(5);
        tick();
        bus.start     = 1'b0;
        wait_done("busy_guard", 40);
        for (int i = 0; i < 4; i++) tick();
        check("busy_guard_pops", pops - p0, 3);
        check("busy_guard_idle", bus.busy, 0);
        check("busy_guard_fifo_left", fifo_q.size(), 5);
        fifo_q.delete();
        fifo_refresh();

        // Reset after 3 of 10 pops
        p0 = pops;
        load_frame(10, 8'h70);
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(10);
        tick();
        bus.start     = 1'b0;
        n = 0;
        while (pops - p0 < 3 && n < 30) begin
            tick();
            n++;
        end
        check("rst_mid_reached", pops - p0, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {bus.fifo_rd_en, bus.out_data, bus.out_valid, bus.out_sof,
               bus.out_eof, bus.busy, bus.done, bus.len_err}, 0);
        sb.delete();
        fifo_q.delete();
        fifo_refresh();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_frame("after_rst", 2, 8'hC0, t0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
